commit_arbiter_s: RTL and testbench
===================================

Name: commit_arbiter_s

Overview:
- Arbitrates commit notifications from the scalar-unit execution sources into the single commit port of the scalar reorder buffer.
- Sources: LdSt1, LdSt2, Math, Mv, Vector.
- Each source gets a one-entry pending slot and an accept grant. A round-robin picker drains one slot per cycle into a registered output stage, held until the reorder buffer acknowledges it.

Parameters:
- NUM_SRC, 5, number of commit sources; index 0=LdSt1, 1=LdSt2, 2=Math, 3=Mv, 4=V.
- WIDTH_NO, 8, issue-number width; equals $bits(issue_no_t).
- WIDTH_SRC, $clog2(NUM_SRC), width of the source index.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Req  in  NUM_SRC  per-source commit request; held until granted
- I_No  in  NUM_SRC x WIDTH_NO  per-source issue number; stable while I_Req is high
- O_Grant  out  NUM_SRC  request accepted this cycle (combinational)
- O_Commit_Req  out  1  commit valid toward the reorder buffer (registered)
- O_Commit_No  out  WIDTH_NO  issue number being committed
- O_Commit_Src  out  WIDTH_SRC  index of the originating source
- I_Commit_Ack  in  1  reorder buffer accepts O_Commit_No this cycle
- O_Num_Pend  out  $clog2(NUM_SRC+2)  occupied slots plus the output stage
- O_Empty  out  1  no pending slot and no output valid

Behaviour:
- Reset values:
  - all slots invalid; Out_V=0; RR pointer=0.
  - O_Commit_Req=0, O_Commit_No=0, O_Commit_Src=0, O_Num_Pend=0, O_Empty=1.
  - O_Grant=0 while reset is high.
- Output stage loadable: Load_Ok = ~Out_V | I_Commit_Ack.
- Picker:
  - Scans Pend_V starting at index Ptr, wrapping modulo NUM_SRC; the first valid slot wins.
  - Fire = Load_Ok & (Pend_V != 0).
- On Fire:
  - Out_No <= Pend_No[win]; Out_Src <= win; Out_V <= 1.
  - Pend_V[win] cleared; Ptr <= (win+1) mod NUM_SRC.
- On I_Commit_Ack without Fire: Out_V <= 0. Ptr changes only on Fire.
- Grant rule: O_Grant[s] = I_Req[s] & (~Pend_V[s] | (Fire & win==s)).
  - On grant: Pend_V[s] <= 1; Pend_No[s] <= I_No[s].
  - A slot may be drained and refilled in the same cycle.
- Latency: a request granted at edge N is in its slot after N, and O_Commit_Req rises after edge N+1 at the earliest.
- Throughput: one commit per cycle when I_Commit_Ack is held high (back-to-back Fire).
- I_Commit_Ack while Out_V=0 is ignored.
- Ordering: no reordering within one source, since each source has a single slot. Fairness: every pending slot is served within NUM_SRC Fires.
- O_Num_Pend = popcount(Pend_V) + Out_V, registered-state derived; max NUM_SRC+1.
- Reset mid-operation: all pending and output entries are discarded. Sources must re-present their requests after reset.

Optional Feature:
- Macro COMMIT_ARB_PRIO_V_EN.
- Defined:
  - Slot 4 (V) has absolute priority: if Pend_V[4], it wins regardless of Ptr.
  - A V win does not update Ptr. Other sources stay round-robin among themselves.
- Undefined: pure round-robin over all NUM_SRC slots, as described above.

Decomposition:
- In pkg_tpu:
  - issue_no_t (already present).
  - commit_src_t enum: LDST1, LDST2, MATH, MV, VEC.
  - struct commit_arb_out_t {v, src, issue_no} for the output stage.
- One natural sub-module: rr_picker (NUM_SRC-wide round-robin find-first from pointer). Returns win index and any-valid; pure combinational, reusable by the vector unit.

Test Plan:
- Single request, ack tied high:
  - I_Req[2]=1, I_No[2]=0x15 at cycle 0 with ack=1 → O_Grant[2]=1 in cycle 0.
  - O_Commit_Req=1, No=0x15, Src=2 in cycle 2; low in cycle 3.
- All five request at cycle 0, No=0x10..0x14, ack=1 → commits appear in cycles 2..6 in order Src 0,1,2,3,4; O_Num_Pend=5 in cycle 1.
- Backpressure:
  - ack=0, sources 0 and 1 pending → O_Commit_Req stays high with No unchanged, and no further Fire.
  - Source 0 re-requesting while its slot is full gets O_Grant[0]=0.
  - Ack pulse for one cycle → next entry loads the following cycle.
- Same-cycle drain and refill: source 3 pending and winning Fire while I_Req[3] presents 0x22 → O_Grant[3]=1 that cycle; 0x22 commits on a later Fire.
- Reset mid-operation: 3 slots full and Out_V=1, assert reset one cycle → O_Commit_Req=0, O_Num_Pend=0, O_Empty=1, Ptr=0; the first post-reset Fire scans from slot 0.
- COMMIT_ARB_PRIO_V_EN defined, slots 0,1,4 pending with Ptr=0 → order 4,0,1. Undefined → order 0,1,4.

Source files
------------

// File: rtl/pkg_tpu.sv
// -----------------------------------------------------------------------------
// pkg_tpu
// Shared types for the scalar-unit commit path.
//   issue_no_t        : issue number carried from the execution sources to the
//                       scalar reorder buffer.
//   commit_src_t      : commit source index (LDST1, LDST2, MATH, MV, VEC).
//   commit_arb_out_t  : registered output stage of commit_arbiter_s
//                       {valid, source index, issue number}.
// -----------------------------------------------------------------------------
package pkg_tpu;

    localparam int CA_NUM_SRC   = 5;
    localparam int CA_WIDTH_NO  = 8;
    localparam int CA_WIDTH_SRC = $clog2(CA_NUM_SRC);

    typedef logic [CA_WIDTH_NO-1:0] issue_no_t;

    typedef enum logic [CA_WIDTH_SRC-1:0] {
        LDST1 = 3'd0,
        LDST2 = 3'd1,
        MATH  = 3'd2,
        MV    = 3'd3,
        VEC   = 3'd4
    } commit_src_t;

    typedef struct packed {
        logic        v;
        commit_src_t src;
        issue_no_t   issue_no;
    } commit_arb_out_t;

endpackage

// File: rtl/commit_arbiter_s_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Round-robin find-first: scans req starting at index ptr, wrapping modulo N,
// and reports the first set bit. Purely combinational.
//   req  in  N   candidate vector
//   ptr  in  W   index where the scan starts (must be < N)
//   win  out W   index of the first set bit at or after ptr (0 when none)
//   any  out 1   at least one bit of req is set
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] win,
    output logic         any
);

    int pos;

    // NOTE: every output and temporary gets a value before the loop so no
    // path through the block leaves a signal unassigned, which would infer a
    // latch.
    always_comb begin
        win = '0;
        any = 1'b0;
        pos = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos]) begin
                any = 1'b1;
                win = W'(pos);
            end
        end
    end

endmodule

// File: rtl/commit_arbiter_s.sv
// -----------------------------------------------------------------------------
// commit_arbiter_s
// Merges commit notifications from the scalar-unit execution sources
// (0=LdSt1, 1=LdSt2, 2=Math, 3=Mv, 4=Vector) into the single commit port of
// the scalar reorder buffer. Each source owns a one-entry pending slot; a
// round-robin picker drains one slot per cycle into a registered output stage
// that is held until the reorder buffer acknowledges it.
//
// Build option: define COMMIT_ARB_PRIO_V_EN to give slot 4 (Vector) absolute
// priority; a Vector win leaves the round-robin pointer untouched so the other
// sources keep rotating among themselves. Default build is pure round-robin.
//
// Ports
//   clock         in   1                     clock
//   reset         in   1                     synchronous, active-high reset
//   I_Req         in   NUM_SRC               per-source request, held until granted
//   I_No          in   NUM_SRC x WIDTH_NO    per-source issue number
//   O_Grant       out  NUM_SRC               request accepted this cycle (comb)
//   O_Commit_Req  out  1                     commit valid (registered)
//   O_Commit_No   out  WIDTH_NO              issue number being committed
//   O_Commit_Src  out  WIDTH_SRC             originating source index
//   I_Commit_Ack  in   1                     reorder buffer takes the commit
//   O_Num_Pend    out  $clog2(NUM_SRC+2)     occupied slots + output stage
//   O_Empty       out  1                     nothing pending, no output valid
// -----------------------------------------------------------------------------
module commit_arbiter_s
    import pkg_tpu::*;
#(
    parameter int NUM_SRC   = CA_NUM_SRC,
    parameter int WIDTH_NO  = $bits(issue_no_t),
    parameter int WIDTH_SRC = $clog2(NUM_SRC)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_SRC-1:0]                I_Req,
    input  logic [NUM_SRC-1:0][WIDTH_NO-1:0]  I_No,
    output logic [NUM_SRC-1:0]                O_Grant,
    output logic                              O_Commit_Req,
    output logic [WIDTH_NO-1:0]               O_Commit_No,
    output logic [WIDTH_SRC-1:0]              O_Commit_Src,
    input  logic                              I_Commit_Ack,
    output logic [$clog2(NUM_SRC+2)-1:0]      O_Num_Pend,
    output logic                              O_Empty
);

    localparam int CNT_W = $clog2(NUM_SRC + 2);

    // Pending slots and output stage.
    logic [NUM_SRC-1:0]  pend_v;
    logic [WIDTH_NO-1:0] pend_no [NUM_SRC];
    commit_arb_out_t     out_q;
    logic [WIDTH_SRC-1:0] ptr;

    // Picker / control.
    logic [NUM_SRC-1:0]   rr_req;
    logic [WIDTH_SRC-1:0] rr_win;
    logic                 rr_any;
    logic [WIDTH_SRC-1:0] win;
    logic                 any_pend;
    logic                 ptr_adv;
    logic [WIDTH_SRC-1:0] next_ptr;
    logic                 load_ok;
    logic                 fire;
    logic [NUM_SRC-1:0]   drain_oh;
    logic [NUM_SRC-1:0]   grant;

`ifdef COMMIT_ARB_PRIO_V_EN
    localparam int V_IDX = int'(VEC);

    // Vector is taken out of the rotation and overrides it when pending.
    assign rr_req   = pend_v & ~(NUM_SRC'(1) << V_IDX);
    assign win      = pend_v[V_IDX] ? WIDTH_SRC'(V_IDX) : rr_win;
    assign any_pend = pend_v[V_IDX] | rr_any;
    assign ptr_adv  = fire & ~pend_v[V_IDX];
`else
    assign rr_req   = pend_v;
    assign win      = rr_win;
    assign any_pend = rr_any;
    assign ptr_adv  = fire;
`endif

    rr_picker #(
        .N (NUM_SRC),
        .W (WIDTH_SRC)
    ) u_rr_picker (
        .req (rr_req),
        .ptr (ptr),
        .win (rr_win),
        .any (rr_any)
    );

    // The output stage can take a new entry when empty or when the current
    // entry leaves this cycle.
    assign load_ok  = ~out_q.v | I_Commit_Ack;
    assign fire     = load_ok & any_pend;
    assign drain_oh = fire ? (NUM_SRC'(1) << win) : '0;
    assign next_ptr = (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;

    // A slot being drained this cycle can accept its source's next request.
    assign grant    = {NUM_SRC{~reset}} & I_Req & (~pend_v | drain_oh);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of the order
    // of statements or processes.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_v <= '0;
            out_q  <= '0;
            ptr    <= '0;
        end else begin
            if (fire) begin
                out_q.v        <= 1'b1;
                out_q.src      <= commit_src_t'(win);
                out_q.issue_no <= pend_no[win];
            end else if (I_Commit_Ack) begin
                out_q.v <= 1'b0;
            end
            if (ptr_adv) begin
                ptr <= next_ptr;
            end
            pend_v <= (pend_v & ~drain_oh) | grant;
        end
    end

    // NOTE: the slot payload has no reset; it is only ever read through
    // pend_v, which is reset, so clearing the data would cost flops for no
    // observable effect.
    always_ff @(posedge clock) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (grant[s]) begin
                pend_no[s] <= I_No[s];
            end
        end
    end

    assign O_Grant      = grant;
    assign O_Commit_Req = out_q.v;
    assign O_Commit_No  = out_q.issue_no;
    assign O_Commit_Src = out_q.src;
    assign O_Num_Pend   = CNT_W'($countones(pend_v)) + CNT_W'(out_q.v);
    assign O_Empty      = ~(|pend_v) & ~out_q.v;

endmodule

// File: tb/tb_commit_arbiter_s.sv
// -----------------------------------------------------------------------------
// tb_commit_arbiter_s
// Self-checking bench for commit_arbiter_s: a table of hand-derived cycle
// vectors, hand-written multi-cycle sequences, and a randomized run compared
// against a slot/queue-level reference model. Define COMMIT_ARB_PRIO_V_EN to
// check the Vector-priority build.
// -----------------------------------------------------------------------------
module tb_commit_arbiter_s;

    localparam int N = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     I_Req;
    logic [N-1:0][7:0] I_No;
    logic [N-1:0]     O_Grant;
    logic             O_Commit_Req;
    logic [7:0]       O_Commit_No;
    logic [2:0]       O_Commit_Src;
    logic             I_Commit_Ack;
    logic [2:0]       O_Num_Pend;
    logic             O_Empty;

    commit_arbiter_s dut (
        .clock        (clock),
        .reset        (reset),
        .I_Req        (I_Req),
        .I_No         (I_No),
        .O_Grant      (O_Grant),
        .O_Commit_Req (O_Commit_Req),
        .O_Commit_No  (O_Commit_No),
        .O_Commit_Src (O_Commit_Src),
        .I_Commit_Ack (I_Commit_Ack),
        .O_Num_Pend   (O_Num_Pend),
        .O_Empty      (O_Empty)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (slot view) ----------------
    bit         m_pv [N];
    logic [7:0] m_pno [N];
    bit         m_ov;
    logic [7:0] m_ono;
    int         m_osrc;
    int         m_ptr;

    // Observed outputs of the most recent step (sampled mid-cycle).
    logic [N-1:0] obs_grant;
    logic         obs_req;
    logic [7:0]   obs_no;
    logic [2:0]   obs_src;
    logic [2:0]   obs_pend;
    logic         obs_empty;

    function automatic int m_pick();
        int w;
        w = -1;
`ifdef COMMIT_ARB_PRIO_V_EN
        if (m_pv[4]) return 4;
`endif
        for (int k = 0; k < N; k++) begin
            if (w < 0 && m_pv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        return w;
    endfunction

    // One clock cycle: drive inputs just after the edge, sample and compare
    // against the model mid-cycle, then advance the model across the edge.
    task automatic step(input logic rst, input logic [N-1:0] req,
                        input logic [N-1:0][7:0] no, input logic ack);
        int w;
        bit fire;
        int cnt;
        logic [N-1:0] eg;
        reset        = rst;
        I_Req        = req;
        I_No         = no;
        I_Commit_Ack = ack;
        @(negedge clock);
        obs_grant = O_Grant;
        obs_req   = O_Commit_Req;
        obs_no    = O_Commit_No;
        obs_src   = O_Commit_Src;
        obs_pend  = O_Num_Pend;
        obs_empty = O_Empty;

        cnt = 0;
        for (int s = 0; s < N; s++) cnt += int'(m_pv[s]);
        w    = m_pick();
        fire = (!m_ov || ack) && (w >= 0);
        for (int s = 0; s < N; s++)
            eg[s] = !rst && req[s] && (!m_pv[s] || (fire && w == s));

        check("mdl_grant",      32'(obs_grant), 32'(eg));
        check("mdl_commit_req", 32'(obs_req),   32'(m_ov));
        check("mdl_commit_no",  32'(obs_no),    32'(m_ono));
        check("mdl_commit_src", 32'(obs_src),   32'(m_osrc));
        check("mdl_num_pend",   32'(obs_pend),  32'(cnt + int'(m_ov)));
        check("mdl_empty",      32'(obs_empty), 32'(cnt == 0 && !m_ov));

        @(posedge clock);
        #1;
        if (rst) begin
            for (int s = 0; s < N; s++) m_pv[s] = 1'b0;
            m_ov = 1'b0; m_ono = '0; m_osrc = 0; m_ptr = 0;
        end else begin
            if (fire) begin
                m_ov   = 1'b1;
                m_ono  = m_pno[w];
                m_osrc = w;
                m_pv[w] = 1'b0;
`ifdef COMMIT_ARB_PRIO_V_EN
                if (w != 4) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
            end else if (ack) begin
                m_ov = 1'b0;
            end
            for (int s = 0; s < N; s++) begin
                if (eg[s]) begin
                    m_pv[s]  = 1'b1;
                    m_pno[s] = no[s];
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic              rst;
        logic [N-1:0]      req;
        logic [N-1:0][7:0] no;
        logic              ack;
        logic [N-1:0]      e_grant;
        logic              chk;
        logic              e_req;
        logic [7:0]        e_no;
        logic [2:0]        e_src;
        logic [2:0]        e_pend;
        logic              e_empty;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [N-1:0] req, logic [N-1:0][7:0] no,
                                logic ack, logic [N-1:0] eg, logic chk, logic er,
                                logic [7:0] en, logic [2:0] es, logic [2:0] ep, logic ee);
        vec_t v;
        v.rst = rst; v.req = req; v.no = no; v.ack = ack; v.e_grant = eg;
        v.chk = chk; v.e_req = er; v.e_no = en; v.e_src = es; v.e_pend = ep; v.e_empty = ee;
        return v;
    endfunction

    initial begin
        logic [N-1:0][7:0] na, nb, nv;
        int ordb [N];
        int ordp [3];
        logic [N-1:0]      sreq;
        logic [N-1:0][7:0] sno;
        logic              rack;
        logic              rrst;

        reset = 1'b1; I_Req = '0; I_No = '0; I_Commit_Ack = 1'b0;
        for (int s = 0; s < N; s++) begin m_pv[s] = 1'b0; m_pno[s] = '0; end
        m_ov = 1'b0; m_ono = '0; m_osrc = 0; m_ptr = 0;
        @(posedge clock);
        #1;

        // Reset state, with every source requesting during reset.
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, 5'b11111, '0, 1'b1);
        check("rst_grant",      32'(obs_grant), 32'h0);
        check("rst_commit_req", 32'(obs_req),   32'h0);
        check("rst_commit_no",  32'(obs_no),    32'h0);
        check("rst_commit_src", 32'(obs_src),   32'h0);
        check("rst_num_pend",   32'(obs_pend),  32'h0);
        check("rst_empty",      32'(obs_empty), 32'h1);

        // Table: single request with ack high, then all five at once.
        na = '0; na[2] = 8'h15;
        for (int s = 0; s < N; s++) nb[s] = 8'(8'h10 + s);
`ifdef COMMIT_ARB_PRIO_V_EN
        ordb = '{4, 0, 1, 2, 3};
`else
        ordb = '{0, 1, 2, 3, 4};
`endif
        tbl.push_back(mk(0, 5'b00100, na, 1, 5'b00100, 1, 0, 8'h00, 3'd0, 3'd0, 1));
        tbl.push_back(mk(0, 5'b00000, na, 1, 5'b00000, 1, 0, 8'h00, 3'd0, 3'd1, 0));
        tbl.push_back(mk(0, 5'b00000, na, 1, 5'b00000, 1, 1, 8'h15, 3'd2, 3'd1, 0));
        tbl.push_back(mk(0, 5'b00000, na, 1, 5'b00000, 1, 0, 8'h00, 3'd0, 3'd0, 1));
        tbl.push_back(mk(1, 5'b11111, nb, 1, 5'b00000, 0, 0, 8'h00, 3'd0, 3'd0, 0));
        tbl.push_back(mk(0, 5'b11111, nb, 1, 5'b11111, 1, 0, 8'h00, 3'd0, 3'd0, 1));
        tbl.push_back(mk(0, 5'b00000, nb, 1, 5'b00000, 1, 0, 8'h00, 3'd0, 3'd5, 0));
        for (int k = 0; k < N; k++)
            tbl.push_back(mk(0, 5'b00000, nb, 1, 5'b00000, 1, 1, 8'(8'h10 + ordb[k]),
                             3'(ordb[k]), 3'(N - k), 0));
        tbl.push_back(mk(0, 5'b00000, nb, 1, 5'b00000, 1, 0, 8'h00, 3'd0, 3'd0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].no, tbl[i].ack);
            check($sformatf("tbl%0d_grant", i), 32'(obs_grant), 32'(tbl[i].e_grant));
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_commit_req", i), 32'(obs_req),   32'(tbl[i].e_req));
                check($sformatf("tbl%0d_num_pend", i),   32'(obs_pend),  32'(tbl[i].e_pend));
                check($sformatf("tbl%0d_empty", i),      32'(obs_empty), 32'(tbl[i].e_empty));
                if (tbl[i].e_req) begin
                    check($sformatf("tbl%0d_commit_no", i),  32'(obs_no),  32'(tbl[i].e_no));
                    check($sformatf("tbl%0d_commit_src", i), 32'(obs_src), 32'(tbl[i].e_src));
                end
            end
        end

        // Backpressure: output held, no further Fire, full slot refuses.
        do_reset();
        nv = '0; nv[0] = 8'h30; nv[1] = 8'h31;
        step(0, 5'b00011, nv, 0);
        check("bp_grant01", 32'(obs_grant), 32'h03);
        nv[0] = 8'h40;
        step(0, 5'b00001, nv, 0);
        check("bp_refill_grant0", 32'(obs_grant), 32'h01);
        nv[0] = 8'h50;
        for (int k = 0; k < 2; k++) begin
            step(0, 5'b00001, nv, 0);
            check("bp_hold_req",   32'(obs_req),   32'h1);
            check("bp_hold_no",    32'(obs_no),    32'h30);
            check("bp_full_grant", 32'(obs_grant), 32'h0);
            check("bp_pend",       32'(obs_pend),  32'h3);
        end
        step(0, 5'b00001, nv, 1);
        check("bp_ack_no", 32'(obs_no), 32'h30);
        step(0, 5'b00001, nv, 0);
        check("bp_next_no",   32'(obs_no),   32'h31);
        check("bp_next_src",  32'(obs_src),  32'h1);
        check("bp_next_pend", 32'(obs_pend), 32'h2);

        // Same-cycle drain and refill of slot 3.
        do_reset();
        nv = '0; nv[3] = 8'h21;
        step(0, 5'b01000, nv, 1);
        nv[3] = 8'h22;
        step(0, 5'b01000, nv, 1);
        check("dr_refill_grant3", 32'(obs_grant), 32'h08);
        step(0, 5'b00000, nv, 1);
        check("dr_first_no", 32'(obs_no),   32'h21);
        check("dr_pend",     32'(obs_pend), 32'h2);
        step(0, 5'b00000, nv, 1);
        check("dr_second_req", 32'(obs_req), 32'h1);
        check("dr_second_no",  32'(obs_no),  32'h22);
        check("dr_second_src", 32'(obs_src), 32'h3);

        // Reset mid-operation: three slots full plus output valid.
        do_reset();
        nv = '0; nv[0] = 8'h61; nv[1] = 8'h62; nv[2] = 8'h63;
        step(0, 5'b00111, nv, 0);
        nv[3] = 8'h64;
        step(0, 5'b01000, nv, 0);
        step(0, 5'b00000, nv, 0);
        check("mr_pre_pend", 32'(obs_pend), 32'h4);
        check("mr_pre_req",  32'(obs_req),  32'h1);
        step(1, 5'b00000, nv, 0);
        nv = '0; nv[0] = 8'h70; nv[3] = 8'h73;
        step(0, 5'b01001, nv, 0);
        check("mr_post_req",   32'(obs_req),   32'h0);
        check("mr_post_pend",  32'(obs_pend),  32'h0);
        check("mr_post_empty", 32'(obs_empty), 32'h1);
        step(0, 5'b00000, nv, 0);
        step(0, 5'b00000, nv, 0);
        check("mr_first_src", 32'(obs_src), 32'h0);
        check("mr_first_no",  32'(obs_no),  32'h70);

        // Slots 0, 1, 4 pending with pointer at 0.
        do_reset();
`ifdef COMMIT_ARB_PRIO_V_EN
        ordp = '{4, 0, 1};
`else
        ordp = '{0, 1, 4};
`endif
        nv = '0; nv[0] = 8'h80; nv[1] = 8'h81; nv[4] = 8'h84;
        step(0, 5'b10011, nv, 1);
        step(0, 5'b00000, nv, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 5'b00000, nv, 1);
            check($sformatf("prio_order%0d", k), 32'(obs_src), 32'(ordp[k]));
        end

        // Randomized traffic against the model; sources hold until granted.
        do_reset();
        sreq = '0; sno = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++) begin
                if (!sreq[s] && $urandom_range(0, 2) == 0) begin
                    sreq[s] = 1'b1;
                    sno[s]  = 8'($urandom);
                end
            end
            rack = ($urandom_range(0, 9) < 7);
            rrst = ($urandom_range(0, 299) == 0);
            step(rrst, sreq, sno, rack);
            sreq = sreq & ~obs_grant;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
